regfile_wr_arbiter: RTL and testbench
=====================================

Name: regfile_wr_arbiter

Overview:
- Shares the single write port of the 8-bit processor register file between two requesters (e.g. ALU writeback and load/immediate path).
- Each requester uses a req/ack handshake. The block latches the winning address and data, holds RegWrite for a programmable number of cycles to cover the register file's delayed write, then acks.
- Round-robin priority by default. Sits between the control/datapath and the register file; the register file's read ports are not touched.

Parameters:
- ADDR_W, 1, register address width (2 registers).
- DATA_W, 8, register data width.
- WR_CYCLES, 2, cycles RegWrite is held per write, minimum 1 (covers the register file's internal write delay).

Ports:
- clk  input  1  single clock, all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req0  input  1  requester 0 write request, held until ack0.
- addr0  input  ADDR_W  requester 0 target register.
- data0  input  DATA_W  requester 0 write data.
- ack0  output  1  one-cycle pulse: requester 0 write committed.
- req1  input  1  requester 1 write request, held until ack1.
- addr1  input  ADDR_W  requester 1 target register.
- data1  input  DATA_W  requester 1 write data.
- ack1  output  1  one-cycle pulse: requester 1 write committed.
- RegWrite  output  1  register file write enable.
- WriteAddr  output  ADDR_W  register file write address (registered).
- WriteData  output  DATA_W  register file write data (registered).
- busy  output  1  high whenever state is not IDLE.

Behaviour:
- All outputs are registered.
- Reset (rst_n low, asynchronous):
  - state = IDLE; RegWrite, ack0, ack1, busy = 0; WriteAddr, WriteData = 0.
  - last_grant = 1, so requester 0 wins the first tie.
  - hold counter = 0.
- States: IDLE, WRITE, ACK.
- IDLE:
  - Sample req0/req1 each edge.
  - Only one req high -> grant it.
  - Both high -> grant the requester not equal to last_grant.
  - On grant: latch addrX/dataX into WriteAddr/WriteData, set RegWrite=1, busy=1, hold counter=WR_CYCLES-1, record the granted id, go to WRITE.
  - Neither high -> stay in IDLE, all outputs unchanged (RegWrite=0).
- WRITE:
  - RegWrite stays 1; WriteAddr/WriteData are frozen, so input changes after grant are ignored.
  - Counter decrements each edge.
  - When counter = 0: RegWrite=0, assert ackX for the granted id, last_grant = granted id, go to ACK.
- ACK:
  - ackX high for exactly this one cycle; no requests are sampled.
  - Next edge: ack cleared, busy=0, go to IDLE.
- Latency: req sampled at edge N -> RegWrite high for cycles N+1 .. N+WR_CYCLES -> ack high in cycle N+WR_CYCLES+1. Minimum spacing between two grants is WR_CYCLES+2 cycles.
- Requester rules:
  - Keep req and its addr/data stable until ack is sampled high, then drop req on that same edge.
  - A req still high in the IDLE cycle after ack is treated as a new request.
- Both requesters targeting the same register: writes are serialized in grant order; the later grant's data remains in the register.
- Starvation: with both reqs continuously high, grants alternate 0,1,0,1...
- Reset mid-WRITE:
  - RegWrite drops asynchronously and no ack is issued. The transaction is aborted and the requester must re-request after reset.
  - Register contents for the aborted write are undefined.
- Never more than one of ack0/ack1 high. RegWrite and any ack are never high in the same cycle.

Optional Feature:
- REGARB_FIXED_PRIO_EN
  - Defined: requester 0 always wins simultaneous requests; last_grant is still updated but is not used for the tie-break. Requester 1 can starve.
  - Undefined: round-robin as above.
- Ports and timing are identical in both builds.

Test Plan:
- Single write (WR_CYCLES=2): req0=1, addr0=1, data0=8'hA5 sampled at edge 0 -> RegWrite=1 in cycles 1-2 with WriteAddr=1, WriteData=8'hA5; ack0 pulse in cycle 3; busy 1 for cycles 1-3; register 1 reads 8'hA5 afterwards.
- Tie after reset: req0=1 (addr 0, data 8'h11) and req1=1 (addr 1, data 8'h22) together -> requester 0 granted first (ack0 in cycle 3), then requester 1 (RegWrite cycles 5-6, ack1 in cycle 7); registers read 8'h11 / 8'h22.
- Fairness: both reqs held high, each re-raised after ack, for 6 transactions -> ack order 0,1,0,1,0,1. With REGARB_FIXED_PRIO_EN defined -> ack order 0,0,0,0,0,0.
- Data freeze: after grant to req1 with data1=8'h3C, change data1 to 8'hFF during WRITE -> WriteData stays 8'h3C; register receives 8'h3C.
- Same-address collision: req0 (addr 0, 8'h01) and req1 (addr 0, 8'h02) simultaneous after reset -> final register 0 value 8'h02; no cycle with both acks high.
- Reset mid-write: assert rst_n=0 in the first RegWrite cycle -> RegWrite, busy, ack0, ack1 go to 0 immediately with no ack pulse; after release, re-issuing the req completes normally with standard latency.

Source files
------------

// File: rtl/regfile_wr_arbiter.sv
// regfile_wr_arbiter: shares the register file's single write port between
// two req/ack requesters. The winner's address/data are latched, RegWrite is
// held for WR_CYCLES cycles to cover the register file's write delay, then a
// one-cycle ack is returned. Ties are broken round-robin by default.
// Optional build macro: REGARB_FIXED_PRIO_EN (requester 0 always wins ties).
module regfile_wr_arbiter #(
  parameter int ADDR_W    = 1,
  parameter int DATA_W    = 8,
  parameter int WR_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] data0,
  output logic              ack0,
  input  logic              req1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] data1,
  output logic              ack1,
  output logic              RegWrite,
  output logic [ADDR_W-1:0] WriteAddr,
  output logic [DATA_W-1:0] WriteData,
  output logic              busy
);

  localparam int CNT_W = (WR_CYCLES > 1) ? $clog2(WR_CYCLES) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    ACK   = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              gnt_q, gnt_d;     // id of the requester being served
  logic              last_q, last_d;   // id of the last completed write
  logic              regwrite_q, regwrite_d;
  logic              ack0_q, ack0_d;
  logic              ack1_q, ack1_d;
  logic              busy_q, busy_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              pick1;

  // State and output registers; reset aborts any write in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      gnt_q      <= 1'b0;
      last_q     <= 1'b1;
      regwrite_q <= 1'b0;
      ack0_q     <= 1'b0;
      ack1_q     <= 1'b0;
      busy_q     <= 1'b0;
      waddr_q    <= '0;
      wdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      gnt_q      <= gnt_d;
      last_q     <= last_d;
      regwrite_q <= regwrite_d;
      ack0_q     <= ack0_d;
      ack1_q     <= ack1_d;
      busy_q     <= busy_d;
      waddr_q    <= waddr_d;
      wdata_q    <= wdata_d;
    end
  end

  // Next-state logic: arbitration in IDLE, hold count in WRITE, ack pulse in ACK.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    gnt_d      = gnt_q;
    last_d     = last_q;
    regwrite_d = regwrite_q;
    ack0_d     = 1'b0;
    ack1_d     = 1'b0;
    busy_d     = busy_q;
    waddr_d    = waddr_q;
    wdata_d    = wdata_q;
    pick1      = 1'b0;

    case (state_q)
      IDLE: begin
        regwrite_d = 1'b0;
        busy_d     = 1'b0;
        if (req0 || req1) begin
`ifdef REGARB_FIXED_PRIO_EN
          pick1 = !req0;
`else
          pick1 = req1 && (!req0 || !last_q);
`endif
          gnt_d      = pick1;
          waddr_d    = pick1 ? addr1 : addr0;
          wdata_d    = pick1 ? data1 : data0;
          regwrite_d = 1'b1;
          busy_d     = 1'b1;
          cnt_d      = CNT_W'(WR_CYCLES - 1);
          state_d    = WRITE;
        end
      end
      WRITE: begin
        if (cnt_q == '0) begin
          regwrite_d = 1'b0;
          ack0_d     = !gnt_q;
          ack1_d     = gnt_q;
          last_d     = gnt_q;
          state_d    = ACK;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ACK: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        regwrite_d = 1'b0;
        busy_d     = 1'b0;
        state_d    = IDLE;
      end
    endcase
  end

  assign RegWrite  = regwrite_q;
  assign ack0      = ack0_q;
  assign ack1      = ack1_q;
  assign busy      = busy_q;
  assign WriteAddr = waddr_q;
  assign WriteData = wdata_q;

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Testbench for regfile_wr_arbiter: directed scenarios plus random traffic
// checked cycle by cycle against a transaction-level reference model.
module tb_regfile_wr_arbiter;

  localparam int AW = 1;
  localparam int DW = 8;
  localparam int W  = 2;
`ifdef REGARB_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req0, req1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] data0, data1;
  logic          ack0, ack1, RegWrite, busy;
  logic [AW-1:0] WriteAddr;
  logic [DW-1:0] WriteData;

  always #5 clk = ~clk;

  regfile_wr_arbiter #(.ADDR_W(AW), .DATA_W(DW), .WR_CYCLES(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .addr0(addr0), .data0(data0), .ack0(ack0),
    .req1(req1), .addr1(addr1), .data1(data1), .ack1(ack1),
    .RegWrite(RegWrite), .WriteAddr(WriteAddr), .WriteData(WriteData),
    .busy(busy)
  );

  // Register file sitting behind the write port.
  logic [DW-1:0] rf [2];
  always @(posedge clk) if (RegWrite) rf[WriteAddr] <= WriteData;

  int errors = 0;
  int checks = 0;
  int ack_log[$];

  // Reference model: one transaction at a time, timed from its grant edge.
  bit            m_active;
  int            m_gedge;
  bit            m_gid;
  bit            m_last;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_data;
  logic [DW-1:0] m_regs [2];
  int            ecount = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h t=%0t", tag, obs, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_active = 1'b0;
    m_last   = 1'b1;
    m_addr   = '0;
    m_data   = '0;
  endfunction

  // Called just after each rising edge, while inputs still hold their edge values.
  function automatic void model_edge();
    bit w;
    ecount++;
    if (m_active && (ecount - m_gedge == W + 1)) begin
      m_active = 1'b0;
    end else if (m_active && (ecount - m_gedge == W)) begin
      m_last         = m_gid;
      m_regs[m_addr] = m_data;
    end else if (!m_active && (req0 || req1)) begin
      if (req0 && req1) w = FIXED ? 1'b0 : !m_last;
      else              w = req1;
      m_active = 1'b1;
      m_gedge  = ecount;
      m_gid    = w;
      m_addr   = w ? addr1 : addr0;
      m_data   = w ? data1 : data0;
    end
  endfunction

  task automatic check_outputs();
    int  o;
    bit  e_rw, e_ack0, e_ack1;
    o      = ecount - m_gedge;
    e_rw   = m_active && (o < W);
    e_ack0 = m_active && (o == W) && !m_gid;
    e_ack1 = m_active && (o == W) && m_gid;
    chk("RegWrite",  RegWrite,  e_rw);
    chk("ack0",      ack0,      e_ack0);
    chk("ack1",      ack1,      e_ack1);
    chk("busy",      busy,      m_active);
    chk("WriteAddr", WriteAddr, m_addr);
    chk("WriteData", WriteData, m_data);
    if (e_ack0 || e_ack1) chk("rf_commit", rf[m_addr], m_data);
  endtask

  // One clock: model update, output check, requester drops req on ack.
  task automatic cyc();
    @(posedge clk);
    model_edge();
    #1;
    check_outputs();
    if (ack0) begin ack_log.push_back(0); req0 = 1'b0; end
    if (ack1) begin ack_log.push_back(1); req1 = 1'b0; end
  endtask

  task automatic drain(input int max);
    int n = 0;
    while ((req0 || req1 || m_active) && n < max) begin
      cyc();
      n++;
    end
    chk("drain_timeout", {31'd0, (req0 || req1 || m_active)}, 32'd0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req0  = 1'b0;
    req1  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_RegWrite",  RegWrite,  0);
    chk("rst_busy",      busy,      0);
    chk("rst_acks",      {ack0, ack1}, 0);
    chk("rst_WriteAddr", WriteAddr, 0);
    chk("rst_WriteData", WriteData, 0);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    ack_log.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rf[0] = '0; rf[1] = '0;
    m_regs[0] = '0; m_regs[1] = '0;
    addr0 = '0; addr1 = '0; data0 = '0; data1 = '0;
    model_reset();

    // Single write from requester 0.
    do_reset();
    req0 = 1'b1; addr0 = 1'b1; data0 = 8'hA5;
    drain(20);
    chk("single_rf1", rf[1], 8'hA5);

    // Tie after reset: requester 0 first, then requester 1.
    do_reset();
    req0 = 1'b1; addr0 = 1'b0; data0 = 8'h11;
    req1 = 1'b1; addr1 = 1'b1; data1 = 8'h22;
    drain(30);
    chk("tie_order_n", ack_log.size(), 2);
    if (ack_log.size() == 2) begin
      chk("tie_first",  ack_log[0], 0);
      chk("tie_second", ack_log[1], 1);
    end
    chk("tie_rf0", rf[0], 8'h11);
    chk("tie_rf1", rf[1], 8'h22);

    // Fairness: both requesters continuously re-raise.
    do_reset();
    req0 = 1'b1; addr0 = 1'b0; data0 = 8'h40;
    req1 = 1'b1; addr1 = 1'b1; data1 = 8'h41;
    for (int n = 0; n < 100 && ack_log.size() < 6; n++) begin
      cyc();
      if (!req0) req0 = 1'b1;
      if (!req1) req1 = 1'b1;
    end
    chk("fair_count", {31'd0, ack_log.size() >= 6}, 1);
    for (int i = 0; i < 6; i++)
      if (i < ack_log.size())
        chk($sformatf("fair_order%0d", i), ack_log[i], FIXED ? 0 : (i % 2));
    drain(40);

    // Data freeze: inputs changed after grant are ignored.
    do_reset();
    req1 = 1'b1; addr1 = 1'b0; data1 = 8'h3C;
    cyc();
    data1 = 8'hFF;
    addr1 = 1'b1;
    drain(20);
    chk("freeze_rf0", rf[0], 8'h3C);

    // Same-address collision.
    do_reset();
    req0 = 1'b1; addr0 = 1'b0; data0 = 8'h01;
    req1 = 1'b1; addr1 = 1'b0; data1 = 8'h02;
    drain(30);
    chk("collide_rf0", rf[0], 8'h02);

    // Reset in the first RegWrite cycle, then re-request.
    do_reset();
    req0 = 1'b1; addr0 = 1'b1; data0 = 8'h5A;
    cyc();
    chk("mid_pre_rw", RegWrite, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rw",   RegWrite, 0);
    chk("mid_busy", busy, 0);
    chk("mid_acks", {ack0, ack1}, 0);
    repeat (2) begin
      @(posedge clk); #1;
      chk("mid_hold_acks", {ack0, ack1}, 0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    drain(20);
    chk("mid_rf1", rf[1], 8'h5A);

    // Random traffic against the model.
    do_reset();
    for (int n = 0; n < 400; n++) begin
      if (!req0 && $urandom_range(0, 2) == 0) begin
        req0 = 1'b1; addr0 = AW'($urandom); data0 = DW'($urandom);
      end
      if (!req1 && $urandom_range(0, 2) == 0) begin
        req1 = 1'b1; addr1 = AW'($urandom); data1 = DW'($urandom);
      end
      cyc();
      chk("excl_acks", {ack0 & ack1}, 0);
      chk("excl_rw_ack", {RegWrite & (ack0 | ack1)}, 0);
    end
    drain(30);
    chk("rand_rf0", rf[0], m_regs[0]);
    chk("rand_rf1", rf[1], m_regs[1]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
